// File: rtl/pixel_stream_pkg.sv
// Shared pixel-stream constants: tuser bit positions and the lane-counter
// width helper. Used by the burst packer and by the burst-to-pixel
// sequentializer, so both ends of the chain agree on flag positions.
package pixel_stream_pkg;

    // tuser bit positions on the pixel and burst buses
    localparam int TUSER_FS = 0;   // frame start
    localparam int TUSER_LE = 2;   // line end
    localparam int TUSER_FE = 3;   // frame end

    // Width of a counter that indexes PPB lanes (at least one bit).
    function automatic int lane_cnt_width(input int ppb);
        return (ppb > 1) ? $clog2(ppb) : 1;
    endfunction

endpackage

// File: rtl/burst_packer_if.sv
// AXI-Stream style bus bundle (valid/ready/data/user).
// Handshake: a beat transfers on a rising clk edge where tvalid && tready.
// The master holds tdata/tuser stable while tvalid is high and tready is
// low; tvalid never depends on tready; tready may depend on tvalid.
// Ports:
//   tvalid  master -> slave   beat valid
//   tready  slave  -> master  beat accepted
//   tdata   master -> slave   DATA_W payload
//   tuser   master -> slave   USER_W sideband flags
interface burst_packer_if #(
    parameter int DATA_W = 16,
    parameter int USER_W = 4
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;

    modport master (output tvalid, output tdata, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tuser, output tready);
endinterface

// File: rtl/burst_packer.sv
// burst_packer: packs one-pixel-per-beat stream into PIXELS_PER_BURST-wide
// bursts. Pixel i of a burst sits at bits [(i+1)*W-1 : i*W].
// Ports:
//   clk             rising-edge clock
//   s_axis_resetn   asynchronous active-low reset
//   s_axis          pixel input bus (slave), tuser[0]=FS [2]=LE [3]=FE
//   m_axis          burst output bus (master), tuser[1] always 0
//   err_short_line  sticky: a burst completed on a line/frame end before
//                   its last lane
//   err_resync      sticky: frame start arrived with a partial burst pending
//   cnt_row         current input line (debug)
module burst_packer
    import pixel_stream_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH  = 16,
    parameter int PIXELS_PER_BURST = 16,
    parameter int USER_WIDTH       = 4,
    parameter int IN_COLS          = 160,
    parameter int IN_ROWS          = 100
) (
    input  logic                       clk,
    input  logic                       s_axis_resetn,
    burst_packer_if.slave              s_axis,
    burst_packer_if.master             m_axis,
    output logic                       err_short_line,
    output logic                       err_resync,
    output logic [$clog2(IN_ROWS)-1:0] cnt_row
);

    localparam int LANE_W  = lane_cnt_width(PIXELS_PER_BURST);
    localparam int BURST_W = PIXEL_BIT_WIDTH * PIXELS_PER_BURST;
    localparam int ROW_W   = $clog2(IN_ROWS);
    localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(PIXELS_PER_BURST - 1);
    localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(IN_ROWS - 1);
    localparam logic [USER_WIDTH-1:0] USER_MASK =
        USER_WIDTH'((1 << TUSER_FS) | (1 << TUSER_LE) | (1 << TUSER_FE));

    // Elaboration-time parameter sanity
    if (PIXELS_PER_BURST < 2 || (PIXELS_PER_BURST & (PIXELS_PER_BURST - 1)) != 0) begin : g_bad_ppb
        $error("PIXELS_PER_BURST must be a power of two >= 2");
    end
    if (IN_COLS % PIXELS_PER_BURST != 0) begin : g_bad_cols
        $error("IN_COLS must be a multiple of PIXELS_PER_BURST");
    end
    if (USER_WIDTH < 4) begin : g_bad_user
        $error("USER_WIDTH must be at least 4");
    end

    // Assembly stage
    logic [LANE_W-1:0]     r_lane_cnt;
    logic [BURST_W-1:0]    r_burst;
    logic [USER_WIDTH-1:0] r_user;
    // Output register
    logic                  r_m_valid;
    logic [BURST_W-1:0]    r_m_data;
    logic [USER_WIDTH-1:0] r_m_user;
    // Status
    logic                  r_err_short;
    logic                  r_err_resync;
    logic [ROW_W-1:0]      r_cnt_row;

    logic [USER_WIDTH-1:0] w_in_user;
    logic                  w_fs;
    logic                  w_le;
    logic                  w_fe;
    logic                  w_resync;
    logic [LANE_W-1:0]     w_lane;
    logic                  w_completing;
    logic                  w_short;
    logic                  w_accept;
    logic [BURST_W-1:0]    w_burst_next;
    logic [USER_WIDTH-1:0] w_user_next;
    logic [ROW_W-1:0]      w_row_base;

    // tuser[1] is not carried through to the burst
    assign w_in_user = s_axis.tuser & USER_MASK;
    assign w_fs      = w_in_user[TUSER_FS];
    assign w_le      = w_in_user[TUSER_LE];
    assign w_fe      = w_in_user[TUSER_FE];

    // A frame start on a non-zero lane throws away the partial burst and
    // restarts assembly at lane 0 with this pixel.
    assign w_resync     = w_fs && (r_lane_cnt != '0);
    assign w_lane       = w_resync ? '0 : r_lane_cnt;
    assign w_completing = s_axis.tvalid && ((w_lane == LAST_LANE) || w_le || w_fe);
    assign w_short      = w_completing && (w_lane != LAST_LANE);

    // Only a completing beat needs the output register; it may go ahead when
    // the register is empty or is being drained this same cycle.
    assign s_axis.tready = s_axis_resetn && (!w_completing || !r_m_valid || m_axis.tready);
    assign w_accept      = s_axis.tvalid && s_axis.tready;

    assign w_row_base = w_fs ? '0 : r_cnt_row;

    always_comb begin
        // Assembly clears after each completion, so unwritten lanes stay zero.
        w_burst_next = w_resync ? '0 : r_burst;
        w_burst_next[int'(w_lane) * PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] = s_axis.tdata;
        w_user_next  = (w_resync ? '0 : r_user) | w_in_user;
    end

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            r_lane_cnt   <= '0;
            r_burst      <= '0;
            r_user       <= '0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_user     <= '0;
            r_err_short  <= 1'b0;
            r_err_resync <= 1'b0;
            r_cnt_row    <= '0;
        end else begin
            if (r_m_valid && m_axis.tready) begin
                r_m_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_completing) begin
                    // Overrides the drain above: back-to-back reload
                    r_m_valid  <= 1'b1;
                    r_m_data   <= w_burst_next;
                    r_m_user   <= w_user_next;
                    r_lane_cnt <= '0;
                    r_burst    <= '0;
                    r_user     <= '0;
                end else begin
                    r_lane_cnt <= w_lane + LANE_W'(1);
                    r_burst    <= w_burst_next;
                    r_user     <= w_user_next;
                end

                // A frame start clears the sticky flags unless this very
                // pixel raises them again.
                if (w_fs) begin
                    r_err_short  <= w_short;
                    r_err_resync <= w_resync;
                end else if (w_short) begin
                    r_err_short  <= 1'b1;
                end

                if (w_le) begin
                    r_cnt_row <= (w_row_base == LAST_ROW) ? '0 : w_row_base + ROW_W'(1);
                end else if (w_fs) begin
                    r_cnt_row <= '0;
                end
            end
        end
    end

    assign m_axis.tvalid  = r_m_valid;
    assign m_axis.tdata   = r_m_data;
    assign m_axis.tuser   = r_m_user;
    assign err_short_line = r_err_short;
    assign err_resync     = r_err_resync;
    assign cnt_row        = r_cnt_row;

endmodule

// File: tb/tb_burst_packer.sv
// Self-checking bench for burst_packer.
module tb_burst_packer;
  import pixel_stream_pkg::*;

  localparam int PW      = 16;
  localparam int PPB     = 16;
  localparam int UW      = 4;
  localparam int COLS    = 160;
  localparam int ROWS    = 100;
  localparam int BDW     = PW * PPB;
  localparam int BW      = BDW + UW;
  localparam int ROW_W   = $clog2(ROWS);
  localparam int FRAME_N = COLS * ROWS;
  localparam int RND_ROWS = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  burst_packer_if #(.DATA_W(PW), .USER_W(UW))  s_if ();
  burst_packer_if #(.DATA_W(BDW), .USER_W(UW)) m_if ();

  logic             err_short_line;
  logic             err_resync;
  logic [ROW_W-1:0] cnt_row;

  burst_packer #(
    .PIXEL_BIT_WIDTH (PW),
    .PIXELS_PER_BURST(PPB),
    .USER_WIDTH      (UW),
    .IN_COLS         (COLS),
    .IN_ROWS         (ROWS)
  ) dut (
    .clk           (clk),
    .s_axis_resetn (rst_n),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .err_short_line(err_short_line),
    .err_resync    (err_resync),
    .cnt_row       (cnt_row)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] mon_act;
  int            beat_cnt = 0;
  logic [BW-1:0] cap0, cap9, cap999;
  bit            watch_ready = 0;
  bit            s_ready_dropped = 0;

  always @(negedge clk) begin
    if (rst_n && watch_ready && s_if.tvalid && !s_if.tready) s_ready_dropped = 1;
    if (rst_n && m_if.tvalid && m_if.tready) begin
      mon_act = {m_if.tuser, m_if.tdata};
      if (exp_q.size() == 0) check_val("beat_expected", BW'(0), BW'(1));
      else check_val("beat", mon_act, exp_q.pop_front());
      if (beat_cnt == 0)   cap0 = mon_act;
      if (beat_cnt == 9)   cap9 = mon_act;
      if (beat_cnt == 999) cap999 = mon_act;
      beat_cnt++;
    end
  end

  // Reference packer for well-formed frames
  logic [BDW-1:0] mdl_burst = '0;
  logic [UW-1:0]  mdl_user = '0;
  int             mdl_lane = 0;

  task automatic model_pixel(input logic [PW-1:0] d, input logic [UW-1:0] u);
    mdl_burst[mdl_lane*PW +: PW] = d;
    mdl_user = mdl_user | (u & 4'b1101);
    if (mdl_lane == PPB - 1 || u[2] || u[3]) begin
      exp_q.push_back({mdl_user, mdl_burst});
      mdl_burst = '0;
      mdl_user = '0;
      mdl_lane = 0;
    end else begin
      mdl_lane++;
    end
  endtask

  // ---------------- downstream ready driver ----------------
  int ready_mode = 0;   // 0: held high, 1: random, 2: 40-cycle stall at first burst
  int stall_cnt = 0;
  bit stall_done = 0;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: m_if.tready = 1'($urandom_range(0, 1));
      2: begin
        if (stall_cnt > 0) begin
          m_if.tready = 1'b0;
          stall_cnt--;
        end else if (!stall_done && m_if.tvalid) begin
          m_if.tready = 1'b0;
          stall_cnt = 39;
          stall_done = 1;
        end else begin
          m_if.tready = 1'b1;
        end
      end
      default: m_if.tready = 1'b1;
    endcase
  end

  // ---------------- driver tasks ----------------
  int cur_idx = 0;
  int first_stall_idx = -1;
  bit record_stall = 0;

  task automatic send_pixel(input logic [PW-1:0] d, input logic [UW-1:0] u,
                            input bit use_model, input bit gaps);
    int wait_cyc;
    bit acc;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        s_if.tvalid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tuser  = u;
    wait_cyc = 0;
    acc = 0;
    while (!acc && wait_cyc < 200) begin
      @(negedge clk);
      acc = s_if.tready;
      if (!acc && record_stall && first_stall_idx < 0) first_stall_idx = cur_idx;
      @(posedge clk); #1;
      wait_cyc++;
    end
    s_if.tvalid = 1'b0;
    if (!acc) check_val("s_accept_timeout", BW'(acc), BW'(1));
    if (acc && use_model) model_pixel(d, u);
  endtask

  function automatic logic [UW-1:0] frame_user(input int i, input int total);
    logic [UW-1:0] u;
    u = '0;
    if (i == 0) u[0] = 1'b1;
    if (i % COLS == COLS - 1) u[2] = 1'b1;
    if (i == total - 1) u[3] = 1'b1;
    return u;
  endfunction

  task automatic run_ramp();
    for (int i = 0; i < FRAME_N; i++) begin
      cur_idx = i;
      send_pixel(i[PW-1:0], frame_user(i, FRAME_N), 1, 0);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("drain_queue_empty", BW'(exp_q.size()), BW'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    mdl_burst = '0;
    mdl_user = '0;
    mdl_lane = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Builds one expected burst from a list of lane values (unused lanes zero)
  logic [PW-1:0]  vals[PPB];
  logic [BDW-1:0] eb;

  task automatic push_burst(input int nlanes, input logic [UW-1:0] u);
    eb = '0;
    for (int k = 0; k < nlanes; k++) eb[k*PW +: PW] = vals[k];
    exp_q.push_back({u, eb});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    m_if.tready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_s_tready", BW'(s_if.tready), BW'(0));
    check_val("rst_m_tvalid", BW'(m_if.tvalid), BW'(0));
    check_val("rst_m_tdata", BW'(m_if.tdata), BW'(0));
    check_val("rst_m_tuser", BW'(m_if.tuser), BW'(0));
    check_val("rst_err_short", BW'(err_short_line), BW'(0));
    check_val("rst_err_resync", BW'(err_resync), BW'(0));
    check_val("rst_cnt_row", BW'(cnt_row), BW'(0));
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("s_tready_after_release", BW'(s_if.tready), BW'(1));
    @(posedge clk); #1;

    // 1: ramp frame, ready held high
    ready_mode = 0;
    beat_cnt = 0;
    s_ready_dropped = 0;
    watch_ready = 1;
    run_ramp();
    wait_drain();
    watch_ready = 0;
    check_val("ramp_beats", BW'(beat_cnt), BW'(1000));
    check_val("ramp_tready_never_low", BW'(s_ready_dropped), BW'(0));
    check_val("ramp_b0_lane0", BW'(cap0[0 +: PW]), BW'(0));
    check_val("ramp_b0_lane15", BW'(cap0[15*PW +: PW]), BW'(15));
    check_val("ramp_b0_tuser", BW'(cap0[BDW +: UW]), BW'(4'h1));
    check_val("ramp_b9_tuser", BW'(cap9[BDW +: UW]), BW'(4'h4));
    check_val("ramp_b999_tuser", BW'(cap999[BDW +: UW]), BW'(4'hC));
    check_val("ramp_cnt_row_wrap", BW'(cnt_row), BW'(0));

    // 2: same ramp with a 40-cycle downstream stall at the first burst
    ready_mode = 2;
    stall_done = 0;
    stall_cnt = 0;
    beat_cnt = 0;
    first_stall_idx = -1;
    record_stall = 1;
    run_ramp();
    wait_drain();
    record_stall = 0;
    ready_mode = 0;
    check_val("stall_first_idx", BW'(first_stall_idx), BW'(31));
    check_val("stall_beats", BW'(beat_cnt), BW'(1000));

    // 3: line end on lane 5
    do_reset();
    for (int k = 0; k < PPB; k++) send_pixel(PW'($urandom), (k == 0) ? 4'h1 : 4'h0, 1, 0);
    check_val("full_burst_err_short", BW'(err_short_line), BW'(0));
    for (int k = 0; k < 6; k++) vals[k] = PW'($urandom);
    push_burst(6, 4'h4);
    for (int k = 0; k < 6; k++) send_pixel(vals[k], (k == 5) ? 4'h4 : 4'h0, 0, 0);
    wait_drain();
    check_val("short_err_short", BW'(err_short_line), BW'(1));
    check_val("short_cnt_row", BW'(cnt_row), BW'(1));

    // 4: frame start on the 9th pixel of a burst
    for (int k = 0; k < 8; k++) send_pixel(PW'($urandom), 4'h0, 0, 0);
    for (int k = 0; k < PPB; k++) vals[k] = PW'($urandom);
    push_burst(PPB, 4'h1);
    send_pixel(vals[0], 4'h1, 0, 0);
    check_val("resync_err_resync", BW'(err_resync), BW'(1));
    check_val("resync_err_short", BW'(err_short_line), BW'(0));
    check_val("resync_cnt_row", BW'(cnt_row), BW'(0));
    for (int k = 1; k < PPB; k++) send_pixel(vals[k], 4'h0, 0, 0);
    wait_drain();
    // A clean frame start clears the resync flag
    send_pixel(PW'($urandom), 4'h1, 1, 0);
    check_val("clean_fs_err_resync", BW'(err_resync), BW'(0));
    for (int k = 1; k < PPB; k++) send_pixel(PW'($urandom), 4'h0, 1, 0);
    wait_drain();

    // 5: reset after 7 pixels
    beat_cnt = 0;
    for (int k = 0; k < 7; k++) send_pixel(PW'($urandom), 4'h0, 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #2;
    check_val("midrst_s_tready", BW'(s_if.tready), BW'(0));
    check_val("midrst_m_tvalid", BW'(m_if.tvalid), BW'(0));
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < PPB; k++) vals[k] = PW'($urandom);
    push_burst(PPB, 4'h0);
    for (int k = 0; k < PPB; k++) send_pixel(vals[k], 4'h0, 0, 0);
    wait_drain();
    check_val("post_reset_beats", BW'(beat_cnt), BW'(1));

    // 6: random valid/ready over three frames
    ready_mode = 1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < COLS * RND_ROWS; i++) begin
        send_pixel(PW'($urandom), frame_user(i, COLS * RND_ROWS), 1, 1);
      end
      wait_drain();
      check_val("rnd_cnt_row", BW'(cnt_row), BW'(RND_ROWS));
    end
    ready_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_packer.md
# burst_packer

Packs a single-pixel AXI-Stream (one `PIXEL_BIT_WIDTH` pixel per beat, per-pixel frame/line flags) into wide bursts of `PIXELS_PER_BURST` pixels per beat. It is the inverse of the burst-to-pixel sequentializer. It sits at the egress of the pixel-domain processing chain and produces the burst bus format consumed downstream. Full throughput is sustained: one pixel in per cycle, one burst out every `PIXELS_PER_BURST` cycles.

## Interface
Parameters:
- `PIXEL_BIT_WIDTH`, 16, bits per pixel
- `PIXELS_PER_BURST`, 16, pixels per output beat; power of two, ≥2
- `USER_WIDTH`, 4, tuser width on both sides
- `IN_COLS`, 160, pixels per line; multiple of `PIXELS_PER_BURST`
- `IN_ROWS`, 100, lines per frame

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge
- `s_axis_resetn`  in  1  reset, asynchronous and active-low
- `s_axis_tvalid`  in  1  input pixel valid
- `s_axis_tready`  out  1  input pixel accepted when high with tvalid
- `s_axis_tdata`  in  `PIXEL_BIT_WIDTH`  pixel
- `s_axis_tuser`  in  `USER_WIDTH`  [0] frame start, [2] line end, [3] frame end; [1] ignored
- `m_axis_tvalid`  out  1  burst valid
- `m_axis_tready`  in  1  downstream ready
- `m_axis_tdata`  out  `PIXEL_BIT_WIDTH*PIXELS_PER_BURST`  burst; pixel i occupies bits [(i+1)*W-1 : i*W]
- `m_axis_tuser`  out  `USER_WIDTH`  [0] burst holds the frame-start pixel, [2] burst ends a line, [3] burst ends the frame, [1] always 0
- `err_short_line`  out  1  sticky flag: a line ended mid-burst
- `err_resync`  out  1  sticky flag: frame start arrived mid-burst
- `cnt_row`  out  `$clog2(IN_ROWS)`  current input line (debug)

## Operation
- Assembly stage:
  - `lane_cnt` (`$clog2(PIXELS_PER_BURST)` bits) indexes a burst register.
  - Each accepted pixel is written to lane `lane_cnt`.
  - User flags OR-accumulate into a pending tuser.
- Completion: the burst is complete when the pixel at lane `PIXELS_PER_BURST-1` is accepted, or when a pixel with tuser[2] or tuser[3] is accepted.
  - The complete burst and its flags move to the output register.
  - `lane_cnt` and the pending flags clear.
- Short burst: if completion occurs at a lane below `PIXELS_PER_BURST-1`:
  - lanes above the last written lane are zero;
  - `err_short_line` sets.
- Frame start mid-burst: if tuser[0] arrives with `lane_cnt != 0`:
  - the partial burst is discarded;
  - the pixel is written to lane 0 of a fresh burst;
  - `err_resync` sets.
- Sticky flags clear only on reset or on acceptance of a frame-start pixel that does not itself raise the flag.
- `cnt_row`: zeroed on frame start; incremented on acceptance of a line-end pixel; wraps to 0 after `IN_ROWS-1`.
- Output register holds its value until `m_axis_tvalid && m_axis_tready`. tdata and tuser are stable while tvalid is high and ready is low.
- Backpressure: `s_axis_tready = s_axis_resetn && (!completing_beat || !m_axis_tvalid || m_axis_tready)`.
  - A combinational path from `m_axis_tready` to `s_axis_tready` is permitted.
  - Only completing beats ever stall.
- Simultaneous output handshake and a completing input beat in the same cycle: the output register reloads with no bubble.

## Timing
- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tuser`=0
  - `err_short_line`=0, `err_resync`=0, `cnt_row`=0
  - `lane_cnt`=0
  - `s_axis_tready`=0 while reset is asserted, 1 on the first cycle after release
- Latency: `m_axis_tvalid` rises on the cycle after the completing pixel is accepted.
- Throughput: one burst per `PIXELS_PER_BURST` input beats with `m_axis_tready` held high; zero idle cycles.
- Reset asserted mid-burst or mid-output: all state clears asynchronously; the partial burst is lost and no beat is emitted.
- `s_axis_tvalid` low: `lane_cnt` holds; no timeout flush.

## Structure
- Shared package `pixel_stream_pkg`:
  - tuser bit indices `TUSER_FS=0`, `TUSER_LE=2`, `TUSER_FE=3`
  - the lane-count width function
  - these constants are shared with the sequentializer
- No sub-module; the assembly and output registers live in one module.

## Test plan
Defaults apply unless stated.
- Ramp frame, pixel value = index 0..15999, continuous valid, `m_axis_tready`=1:
  - 1000 bursts out;
  - burst 0 lane 0 = 0, lane 15 = 15, tuser=0x1;
  - burst 9 tuser=0x4;
  - burst 999 tuser=0xC;
  - tready never drops.
- Same ramp with `m_axis_tready` low for 40 cycles after the first burst:
  - `s_axis_tready` drops exactly on the completing beat of burst 1;
  - no pixel is lost or duplicated.
- Line end on pixel 5 of a burst:
  - burst lanes 0..5 hold data, lanes 6..15 = 0, tuser[2]=1;
  - `err_short_line`=1.
- Frame start on the 9th pixel of a burst:
  - first 8 pixels dropped; next output lane 0 = that pixel, tuser[0]=1;
  - `err_resync`=1;
  - `err_short_line` and `cnt_row` cleared to 0.
- Reset pulsed after 7 pixels:
  - no output beat;
  - the next 16 pixels form one burst with lane 0 = the first post-reset pixel.
- Random valid/ready toggling (50%) over 3 frames: the scoreboard matches the golden packed stream bit-exactly.
